// File: rtl/avalon_bus_arbiter.sv
// avalon_bus_arbiter: two-requester Avalon-MM arbiter.
// Port 0 is the instruction-fetch master and port 1 is the data master.
// Both share one Avalon master toward memory. The granted port's request
// path is combinational, so a transfer can finish in its first granted cycle.
// Optional macro ARB_ROUND_ROBIN_EN: when both ports contend from idle, the
// port not granted last wins. Without the macro, port 1 always wins.
module avalon_bus_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] p0_address,
    input  logic        p0_read,
    input  logic        p0_write,
    input  logic [31:0] p0_writedata,
    input  logic [3:0]  p0_byteenable,
    output logic        p0_waitrequest,
    output logic [31:0] p0_readdata,
    input  logic [31:0] p1_address,
    input  logic        p1_read,
    input  logic        p1_write,
    input  logic [31:0] p1_writedata,
    input  logic [3:0]  p1_byteenable,
    output logic        p1_waitrequest,
    output logic [31:0] p1_readdata,
    output logic [31:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [31:0] m_writedata,
    output logic [3:0]  m_byteenable,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic [1:0]  grant,
    output logic        protocol_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   protocol_err_q, protocol_err_d;
    logic   req0, req1;

`ifdef ARB_ROUND_ROBIN_EN
    // High when port 1 was the most recent owner.
    logic   last_q, last_d;
`endif

    assign req0 = p0_read | p0_write;
    assign req1 = p1_read | p1_write;

    // Read data goes to both ports; only the owner's waitrequest marks it valid.
    assign p0_readdata  = m_readdata;
    assign p1_readdata  = m_readdata;
    assign protocol_err = protocol_err_q;

    // Arbitration, master-side muxing and protocol checking for the owner.
    always_comb begin
        state_d        = state_q;
        protocol_err_d = protocol_err_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d         = last_q;
`endif
        m_address      = 32'h0;
        m_read         = 1'b0;
        m_write        = 1'b0;
        m_writedata    = 32'h0;
        m_byteenable   = 4'h0;
        p0_waitrequest = 1'b1;
        p1_waitrequest = 1'b1;
        grant          = 2'b00;

        case (state_q)
            IDLE: begin
                if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                    state_d = last_q ? GNT0 : GNT1;
`else
                    state_d = GNT1;
`endif
                end else if (req1) begin
                    state_d = GNT1;
                end else if (req0) begin
                    state_d = GNT0;
                end
            end

            GNT0: begin
                grant          = 2'b01;
                m_address      = p0_address;
                m_write        = p0_write;
                m_read         = p0_read & ~p0_write;
                m_writedata    = p0_writedata;
                m_byteenable   = p0_byteenable;
                p0_waitrequest = m_waitrequest;
                if (!req0) begin
                    // Owner walked away mid-transfer: drop strobes and release.
                    m_read         = 1'b0;
                    m_write        = 1'b0;
                    protocol_err_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    if (p0_read && p0_write) begin
                        protocol_err_d = 1'b1;
                    end
                    if (!m_waitrequest) begin
                        state_d = req1 ? GNT1 : IDLE;
                    end
                end
            end

            GNT1: begin
                grant          = 2'b10;
                m_address      = p1_address;
                m_write        = p1_write;
                m_read         = p1_read & ~p1_write;
                m_writedata    = p1_writedata;
                m_byteenable   = p1_byteenable;
                p1_waitrequest = m_waitrequest;
                if (!req1) begin
                    // Owner walked away mid-transfer: drop strobes and release.
                    m_read         = 1'b0;
                    m_write        = 1'b0;
                    protocol_err_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    if (p1_read && p1_write) begin
                        protocol_err_d = 1'b1;
                    end
                    if (!m_waitrequest) begin
                        state_d = req0 ? GNT0 : IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef ARB_ROUND_ROBIN_EN
        if (state_d == GNT0 && state_q != GNT0) begin
            last_d = 1'b0;
        end else if (state_d == GNT1 && state_q != GNT1) begin
            last_d = 1'b1;
        end
`endif
    end

    // State, sticky error and fairness pointer; reset makes port 1 the last owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            protocol_err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q         <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            protocol_err_q <= protocol_err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q         <= last_d;
`endif
        end
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb_avalon_bus_arbiter: directed scoreboard bench for avalon_bus_arbiter.
// Expectations are queued as each step is driven and compared when the step is sampled.
module tb_avalon_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] p0_address, p0_writedata, p0_readdata;
    logic        p0_read, p0_write, p0_waitrequest;
    logic [3:0]  p0_byteenable;
    logic [31:0] p1_address, p1_writedata, p1_readdata;
    logic        p1_read, p1_write, p1_waitrequest;
    logic [3:0]  p1_byteenable;
    logic [31:0] m_address, m_writedata, m_readdata;
    logic        m_read, m_write, m_waitrequest;
    logic [3:0]  m_byteenable;
    logic [1:0]  grant;
    logic        protocol_err;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [1:0] FIRST_WIN = 2'b01;
`else
    localparam logic [1:0] FIRST_WIN = 2'b10;
`endif

    always #5 clk = ~clk;

    avalon_bus_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .p0_address     (p0_address),
        .p0_read        (p0_read),
        .p0_write       (p0_write),
        .p0_writedata   (p0_writedata),
        .p0_byteenable  (p0_byteenable),
        .p0_waitrequest (p0_waitrequest),
        .p0_readdata    (p0_readdata),
        .p1_address     (p1_address),
        .p1_read        (p1_read),
        .p1_write       (p1_write),
        .p1_writedata   (p1_writedata),
        .p1_byteenable  (p1_byteenable),
        .p1_waitrequest (p1_waitrequest),
        .p1_readdata    (p1_readdata),
        .m_address      (m_address),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_writedata    (m_writedata),
        .m_byteenable   (m_byteenable),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .grant          (grant),
        .protocol_err   (protocol_err)
    );

    // Wait for the next rising edge, then drive strobes just after it.
    task automatic applyStimulus(input logic r0, input logic w0, input logic r1,
                                 input logic w1, input logic mw);
        @(posedge clk);
        #1;
        p0_read       = r0;
        p0_write      = w0;
        p1_read       = r1;
        p1_write      = w1;
        m_waitrequest = mw;
    endtask

    task automatic expectVal(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the observed value.
    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $error("[TB] FAIL scoreboard_empty: observed %0h required <nothing queued>", observed);
        end else begin
            e = sb_q.pop_front();
            assert (observed === e.value) else begin
                mismatched++;
                $error("[TB] FAIL %s: observed %0h required %0h", e.tag, observed, e.value);
            end
        end
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required sequence end");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence of steps.
    initial begin
        reset         = 1'b0;
        p0_address    = 32'h0;
        p0_writedata  = 32'h0;
        p0_byteenable = 4'h0;
        p0_read       = 1'b0;
        p0_write      = 1'b0;
        p1_address    = 32'h0;
        p1_writedata  = 32'h0;
        p1_byteenable = 4'h0;
        p1_read       = 1'b0;
        p1_write      = 1'b0;
        m_waitrequest = 1'b0;
        m_readdata    = 32'hCAFE_0001;

        // Held in reset while port 0 requests: nothing may be granted.
        applyStimulus(1, 0, 0, 0, 0);
        expectVal("rst_grant", 32'h0);
        expectVal("rst_p0_wait", 32'h1);
        expectVal("rst_p1_wait", 32'h1);
        expectVal("rst_m_read", 32'h0);
        expectVal("rst_m_write", 32'h0);
        expectVal("rst_err", 32'h0);
        @(negedge clk);
        checkOutput({30'h0, grant});
        checkOutput({31'h0, p0_waitrequest});
        checkOutput({31'h0, p1_waitrequest});
        checkOutput({31'h0, m_read});
        checkOutput({31'h0, m_write});
        checkOutput({31'h0, protocol_err});

        applyStimulus(1, 0, 0, 0, 0);
        expectVal("rst_hold_grant", 32'h0);
        @(negedge clk);
        checkOutput({30'h0, grant});

        // Single fetch from the reset vector with zero memory wait.
        p0_address = 32'hBFC0_0000;
        p1_address = 32'h1000_0000;
        m_readdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        reset = 1'b1;
        expectVal("release_grant", 32'h0);
        @(negedge clk);
        checkOutput({30'h0, grant});

        applyStimulus(1, 0, 0, 0, 0);
        expectVal("fetch_grant", 32'h1);
        expectVal("fetch_addr", 32'hBFC0_0000);
        expectVal("fetch_m_read", 32'h1);
        expectVal("fetch_p0_wait", 32'h0);
        expectVal("fetch_rdata", 32'h1234_5678);
        expectVal("fetch_p1_wait", 32'h1);
        @(negedge clk);
        checkOutput({30'h0, grant});
        checkOutput(m_address);
        checkOutput({31'h0, m_read});
        checkOutput({31'h0, p0_waitrequest});
        checkOutput(p0_readdata);
        checkOutput({31'h0, p1_waitrequest});

        applyStimulus(0, 0, 0, 0, 0);
        expectVal("fetch_done_grant", 32'h0);
        @(negedge clk);
        checkOutput({30'h0, grant});

        // Contention from idle with a stalled memory: data port goes first.
        p0_address    = 32'h0000_0400;
        p1_address    = 32'h2000_0010;
        p1_writedata  = 32'hDEAD_BEEF;
        p1_byteenable = 4'hF;
        applyStimulus(1, 0, 0, 1, 1);
        expectVal("cont_idle_grant", 32'h0);
        @(negedge clk);
        checkOutput({30'h0, grant});

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 1, 1);
            expectVal($sformatf("cont_stall%0d_grant", i), 32'h2);
            expectVal($sformatf("cont_stall%0d_p0_wait", i), 32'h1);
            expectVal($sformatf("cont_stall%0d_p1_wait", i), 32'h1);
            expectVal($sformatf("cont_stall%0d_m_write", i), 32'h1);
            expectVal($sformatf("cont_stall%0d_addr", i), 32'h2000_0010);
            expectVal($sformatf("cont_stall%0d_wdata", i), 32'hDEAD_BEEF);
            @(negedge clk);
            checkOutput({30'h0, grant});
            checkOutput({31'h0, p0_waitrequest});
            checkOutput({31'h0, p1_waitrequest});
            checkOutput({31'h0, m_write});
            checkOutput(m_address);
            checkOutput(m_writedata);
        end

        applyStimulus(1, 0, 0, 1, 0);
        expectVal("cont_p1_done_grant", 32'h2);
        expectVal("cont_p1_done_p1_wait", 32'h0);
        expectVal("cont_p1_done_p0_wait", 32'h1);
        expectVal("cont_p1_done_be", 32'hF);
        @(negedge clk);
        checkOutput({30'h0, grant});
        checkOutput({31'h0, p1_waitrequest});
        checkOutput({31'h0, p0_waitrequest});
        checkOutput({28'h0, m_byteenable});

        applyStimulus(1, 0, 0, 0, 0);
        expectVal("cont_handoff_grant", 32'h1);
        expectVal("cont_handoff_m_read", 32'h1);
        expectVal("cont_handoff_m_write", 32'h0);
        expectVal("cont_handoff_addr", 32'h0000_0400);
        expectVal("cont_handoff_p0_wait", 32'h0);
        @(negedge clk);
        checkOutput({30'h0, grant});
        checkOutput({31'h0, m_read});
        checkOutput({31'h0, m_write});
        checkOutput(m_address);
        checkOutput({31'h0, p0_waitrequest});

        applyStimulus(0, 0, 0, 0, 0);
        expectVal("cont_end_grant", 32'h0);
        expectVal("cont_end_err", 32'h0);
        @(negedge clk);
        checkOutput({30'h0, grant});
        checkOutput({31'h0, protocol_err});

        // Port 0 abandons its read while memory is stalling.
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1);
        expectVal("abandon_pre_grant", 32'h1);
        expectVal("abandon_pre_m_read", 32'h1);
        expectVal("abandon_pre_p0_wait", 32'h1);
        @(negedge clk);
        checkOutput({30'h0, grant});
        checkOutput({31'h0, m_read});
        checkOutput({31'h0, p0_waitrequest});

        applyStimulus(0, 0, 0, 0, 1);
        expectVal("abandon_m_read", 32'h0);
        expectVal("abandon_grant", 32'h1);
        expectVal("abandon_err_not_yet", 32'h0);
        @(negedge clk);
        checkOutput({31'h0, m_read});
        checkOutput({30'h0, grant});
        checkOutput({31'h0, protocol_err});

        applyStimulus(0, 0, 0, 0, 1);
        expectVal("abandon_idle_grant", 32'h0);
        expectVal("abandon_err", 32'h1);
        @(negedge clk);
        checkOutput({30'h0, grant});
        checkOutput({31'h0, protocol_err});

        applyStimulus(0, 0, 0, 0, 0);
        expectVal("abandon_err_sticky", 32'h1);
        @(negedge clk);
        checkOutput({31'h0, protocol_err});

        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        expectVal("err_cleared_by_reset", 32'h0);
        expectVal("err_reset_grant", 32'h0);
        checkOutput({31'h0, protocol_err});
        checkOutput({30'h0, grant});
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Port 1 drives read and write together, then reset hits mid-write.
        p1_address   = 32'h3000_0000;
        p1_writedata = 32'h0BAD_F00D;
        applyStimulus(0, 0, 1, 1, 1);
        applyStimulus(0, 0, 1, 1, 1);
        expectVal("rw_grant", 32'h2);
        expectVal("rw_m_write", 32'h1);
        expectVal("rw_m_read", 32'h0);
        expectVal("rw_err_not_yet", 32'h0);
        @(negedge clk);
        checkOutput({30'h0, grant});
        checkOutput({31'h0, m_write});
        checkOutput({31'h0, m_read});
        checkOutput({31'h0, protocol_err});

        applyStimulus(0, 0, 1, 1, 1);
        expectVal("rw_err", 32'h1);
        expectVal("rw_m_write_held", 32'h1);
        @(negedge clk);
        checkOutput({31'h0, protocol_err});
        checkOutput({31'h0, m_write});

        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        expectVal("midrst_m_write", 32'h0);
        expectVal("midrst_grant", 32'h0);
        expectVal("midrst_err", 32'h0);
        expectVal("midrst_p1_wait", 32'h1);
        checkOutput({31'h0, m_write});
        checkOutput({30'h0, grant});
        checkOutput({31'h0, protocol_err});
        checkOutput({31'h0, p1_waitrequest});
        applyStimulus(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Two rounds of idle contention; loser is served right after the winner.
        for (int r = 0; r < 2; r++) begin
            m_readdata = 32'hA5A5_0000 + 32'(r);
            applyStimulus(1, 0, 1, 0, 0);
            applyStimulus(1, 0, 1, 0, 0);
            expectVal($sformatf("rr%0d_win_grant", r), {30'h0, FIRST_WIN});
            expectVal($sformatf("rr%0d_win_rdata", r), 32'hA5A5_0000 + 32'(r));
            @(negedge clk);
            checkOutput({30'h0, grant});
            checkOutput((FIRST_WIN == 2'b01) ? p0_readdata : p1_readdata);

            if (FIRST_WIN == 2'b01) begin
                applyStimulus(0, 0, 1, 0, 0);
            end else begin
                applyStimulus(1, 0, 0, 0, 0);
            end
            expectVal($sformatf("rr%0d_lose_grant", r), {30'h0, ~FIRST_WIN});
            @(negedge clk);
            checkOutput({30'h0, grant});

            applyStimulus(0, 0, 0, 0, 0);
            expectVal($sformatf("rr%0d_idle_grant", r), 32'h0);
            @(negedge clk);
            checkOutput({30'h0, grant});
        end

        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL %s: observed <never sampled> required %0h", e.tag, e.value);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/avalon_bus_arbiter.md
AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 Parameters: none; all widths fixed (32-bit address/data, 4-bit byteenable).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 pN_address  input  32  requester N address (N=0 instruction fetch, N=1 data).
REQ-005 pN_read / pN_write  input  1 each  requester N read/write strobes.
REQ-006 pN_writedata  input  32; pN_byteenable  input  4  requester N write payload.
REQ-007 pN_waitrequest  output  1  stall to requester N.
REQ-008 pN_readdata  output  32  read data returned to requester N.
REQ-009 m_address  output  32; m_read / m_write  output  1; m_writedata  output  32; m_byteenable  output  4  Avalon master toward memory.
REQ-010 m_waitrequest  input  1; m_readdata  input  32  memory-side response.
REQ-011 grant  output  2  one-hot current owner; 00 when idle.
REQ-012 protocol_err  output  1  sticky flag for illegal requester behaviour.

Function
REQ-013 reqN = pN_read | pN_write; states IDLE, GNT0, GNT1.
REQ-014 IDLE: all m_* outputs 0; both pN_waitrequest = 1; if any reqN, next state = GNTx per arbitration (REQ-018); otherwise stay.
REQ-015 GNTx: m_address/m_read/m_write/m_writedata/m_byteenable combinationally follow port x; px_waitrequest = m_waitrequest; other port's waitrequest = 1.
REQ-016 pN_readdata = m_readdata for both ports at all times; valid only to the granted port in its completion cycle.
REQ-017 Completion = GNTx and reqx and m_waitrequest == 0; on completion, next state = GNT(other) if other port requesting, else IDLE (no bubble on back-to-back contention).
REQ-018 Arbitration in IDLE with both requesting: per REQ-026/027.
REQ-019 Abandon: GNTx with reqx == 0 -> m_read/m_write 0 that cycle; next state IDLE; protocol_err set.
REQ-020 px_read and px_write both high while granted -> m_write forwarded, m_read forced 0; protocol_err set.
REQ-021 Minimum latency: request in IDLE seen on edge k; earliest completion in cycle k+1.
REQ-022 Grant is never removed while m_waitrequest is high and the owner still requests (no preemption).

Reset
REQ-023 Assertion (reset == 0) immediately forces state IDLE, grant 00, m_read/m_write 0, protocol_err 0, both pN_waitrequest 1, last-granted pointer = 1.
REQ-024 Reset mid-transaction aborts it; no completion reported to the requester.
REQ-025 First arbitration after release occurs on the first rising edge with reset == 1.

Configuration
REQ-026 With ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the port not granted last (last-granted pointer updated on every entry to GNTx).
REQ-027 Without ARB_ROUND_ROBIN_EN: fixed priority, port 1 (data) always wins; the pointer is not implemented.

Verification
REQ-028 Reset low mid-GNT1 with m_write high -> m_write 0 and grant 00 in the same cycle; protocol_err 0.
REQ-029 p0_read only, address 0xBFC00000, m_waitrequest low -> grant 01 one cycle later; m_address 0xBFC00000; p0 completes in that cycle with p0_readdata = m_readdata.
REQ-030 p0_read and p1_write together from IDLE, m_waitrequest held high 3 cycles -> grant 10 (both configs); p0_waitrequest 1 throughout; after p1 completes grant 01 on the next edge.
REQ-031 Repeated simultaneous requests, 4 transactions -> with macro grants alternate 01,10,01,10 starting 01 after reset; without macro p1 wins every contention.
REQ-032 GNT0 with p0_read dropped while m_waitrequest 1 -> m_read 0 immediately, state IDLE next edge, protocol_err 1 until reset.
REQ-033 p1_read and p1_write both high granted -> m_write 1, m_read 0, protocol_err 1.
